// File: rtl/spi_defs.sv
// Shared definitions for the SPI register bank: FSM encoding, R/W polarity and frame sizing.
package spi_defs;

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StActive,
        StCommit
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-clk rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI Mode-0 peripheral register bank: write/read frames of R/W, address and data, MSB first,
// with frame-length and address validation. All SPI pins are sampled in the clk domain.
module spi_reg_bank
    import spi_defs::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk_i,
    input  logic                       copi_i,
    input  logic                       ncs_i,
    output logic                       cipo_o,
    output logic                       cipo_oe_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_strobe_o,
    output logic                       frame_err_o
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned HDR_W   = 1 + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (sclk_i),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (copi_i),
        .level_o(copi_s),
        .rise_o (copi_rise),
        .fall_o (copi_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (ncs_i),
        .level_o(ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, copi_rise, copi_fall};

    spi_state_e          state_q;
    logic [FRAME_W-1:0]  shift_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   out_shift_q;
    logic                rd_phase_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_strobe_q;
    logic                frame_err_q;

    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] rd_data;
    logic              frm_rw;
    logic [ADDR_W-1:0] frm_addr;
    logic [DATA_W-1:0] frm_data;
    logic              frm_len_ok;
    logic              frm_addr_ok;

    // Header as it will stand once the current sclk rise has shifted copi in.
    always_comb begin
        hdr     = {shift_q[ADDR_W-1:0], copi_s};
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr[ADDR_W-1:0] == ADDR_W'(k)) begin
                rd_data = regs_q[k];
            end
        end
        frm_rw      = shift_q[FRAME_W-1];
        frm_addr    = shift_q[DATA_W +: ADDR_W];
        frm_data    = shift_q[DATA_W-1:0];
        frm_len_ok  = (count_q == CNT_W'(FRAME_W));
        frm_addr_ok = ({1'b0, frm_addr} < (ADDR_W + 1)'(NUM_REGS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitIdle;
            shift_q     <= '0;
            count_q     <= '0;
            out_shift_q <= '0;
            rd_phase_q  <= 1'b0;
            regs_q      <= '{default: '0};
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                // Synced ncs resets low, so a frame already under way at reset release is skipped.
                StWaitIdle: begin
                    if (ncs_s) state_q <= StIdle;
                end
                StIdle: begin
                    if (ncs_fall) begin
                        state_q     <= StActive;
                        shift_q     <= '0;
                        count_q     <= '0;
                        out_shift_q <= '0;
                        rd_phase_q  <= 1'b0;
                    end
                end
                StActive: begin
                    if (ncs_rise) begin
                        state_q <= StCommit;
                    end else begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[FRAME_W-2:0], copi_s};
                            if (count_q != CNT_W'(FRAME_W + 1)) count_q <= count_q + 1'b1;
                            if (count_q == CNT_W'(ADDR_W) && hdr[ADDR_W] == RW_READ) begin
                                out_shift_q <= rd_data;
                                rd_phase_q  <= 1'b1;
                            end
                        end
                        // The fall right after the load keeps the MSB up for the next rise.
                        if (sclk_fall && rd_phase_q && count_q > CNT_W'(HDR_W)) begin
                            out_shift_q <= out_shift_q << 1;
                        end
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    if (frm_len_ok && frm_addr_ok) begin
                        if (frm_rw == RW_WRITE) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (frm_addr == ADDR_W'(k)) begin
                                    regs_q[k]      <= frm_data;
                                    wr_strobe_q[k] <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= StWaitIdle;
            endcase
        end
    end

    assign cipo_oe_o   = (state_q == StActive) && rd_phase_q;
    assign cipo_o      = cipo_oe_o & out_shift_q[DATA_W-1];
    assign wr_strobe_o = wr_strobe_q;
    assign frame_err_o = frame_err_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus pushes expected commits and read data,
// monitors pop and compare when the DUT strobes, flags an error or finishes a read.
module tb_spi_reg_bank;

    localparam int NR    = 5;
    localparam int DW    = 8;
    localparam int PH    = 4;  // SCLK half-phase in clk periods
    localparam int NCS_H = 5;  // ncs high time between frames

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sclk_i, copi_i, ncs_i;
    logic           cipo_o, cipo_oe_o;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]  wr_strobe_o;
    logic           frame_err_o;

    spi_reg_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk_i     (sclk_i),
        .copi_i     (copi_i),
        .ncs_i      (ncs_i),
        .cipo_o     (cipo_o),
        .cipo_oe_o  (cipo_oe_o),
        .regs_o     (regs_o),
        .wr_strobe_o(wr_strobe_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0]    strobe;
        logic             err;
        logic [NR*DW-1:0] regs;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] model [NR];
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [NR*DW-1:0] flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ncs_low();
        ncs_i = 1'b0;
        wait_clks(PH);
    endtask

    task automatic clock_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi_i = bits[i];
            wait_clks(PH);
            sclk_i = 1'b1;
            wait_clks(PH);
            sclk_i = 1'b0;
        end
    endtask

    task automatic ncs_high();
        wait_clks(PH);
        ncs_i = 1'b1;
        wait_clks(NCS_H);
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        ncs_low();
        clock_bits(bits, n);
        ncs_high();
    endtask

    task automatic exp_write(input int addr, input logic [7:0] data);
        ev_t e;
        model[addr] = data;
        e.strobe = NR'(1) << addr;
        e.err    = 1'b0;
        e.regs   = flat();
        exp_q.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        e.strobe = '0;
        e.err    = 1'b1;
        e.regs   = flat();
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_regs(input string name);
        @(negedge clk);
        checks++;
        if (regs_o !== flat()) begin
            failures++;
            $display("FAIL %s: regs_o=%h required %h", name, regs_o, flat());
        end
    endtask

    // Commit monitor: every strobe or error pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (!cipo_oe_o && cipo_o !== 1'b0) begin
                failures++;
                $display("FAIL cipo_idle: cipo_o=%b required 0 while cipo_oe_o low", cipo_o);
            end
            if (wr_strobe_o != '0 || frame_err_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: strobe=%b err=%b required no event",
                             wr_strobe_o, frame_err_o);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    checks += 3;
                    if (wr_strobe_o !== e.strobe) begin
                        failures++;
                        $display("FAIL strobe: got %b required %b", wr_strobe_o, e.strobe);
                    end
                    if (frame_err_o !== e.err) begin
                        failures++;
                        $display("FAIL frame_err: got %b required %b", frame_err_o, e.err);
                    end
                    if (regs_o !== e.regs) begin
                        failures++;
                        $display("FAIL regs_at_event: got %h required %h", regs_o, e.regs);
                    end
                end
            end
        end
    end

    // Read monitor: collect CIPO at each SCLK rise while enabled, compare at ncs rise.
    logic [7:0] rd_data = '0;
    int         rd_bits = 0;
    always @(posedge sclk_i or posedge ncs_i) begin
        if (ncs_i) begin
            if (rd_bits != 0) begin
                checks += 2;
                if (rd_bits != 8) begin
                    failures++;
                    $display("FAIL read_len: cipo_oe bits=%0d required 8", rd_bits);
                end
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL read_data: got %h with no read expected", rd_data);
                end else begin
                    logic [7:0] x;
                    x = rd_q.pop_front();
                    if (rd_data !== x) begin
                        failures++;
                        $display("FAIL read_data: got %h required %h", rd_data, x);
                    end
                end
            end
            rd_bits = 0;
            rd_data = '0;
        end else if (cipo_oe_o) begin
            rd_data = {rd_data[6:0], cipo_o};
            rd_bits++;
        end
    end

    initial begin
        for (int k = 0; k < NR; k++) model[k] = '0;
        rst_n  = 1'b0;
        sclk_i = 1'b0;
        copi_i = 1'b0;
        ncs_i  = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (regs_o !== '0)      begin failures++; $display("FAIL rst_regs: got %h required 0", regs_o); end
        if (wr_strobe_o !== '0) begin failures++; $display("FAIL rst_strobe: got %b required 0", wr_strobe_o); end
        if (frame_err_o !== 0)  begin failures++; $display("FAIL rst_err: got %b required 0", frame_err_o); end
        if (cipo_o !== 0)       begin failures++; $display("FAIL rst_cipo: got %b required 0", cipo_o); end
        if (cipo_oe_o !== 0)    begin failures++; $display("FAIL rst_cipo_oe: got %b required 0", cipo_oe_o); end
        wait_clks(1);
        rst_n = 1'b1;
        wait_clks(6);

        exp_write(0, 8'hA5);
        send(32'h80A5, 16);
        drain("write_a5");

        exp_write(3, 8'h5A);
        send(32'h835A, 16);
        drain("write_5a");
        rd_q.push_back(8'h5A);
        send(32'h0300, 16);
        drain("read_reg3");
        check_regs("regs_after_read");

        exp_err();
        send(32'h407F, 15);
        drain("short_frame");
        exp_err();
        send(32'h101FE, 17);
        drain("long_frame");
        check_regs("regs_after_len_err");

        exp_err();
        send(32'h8511, 16);
        drain("bad_addr");
        check_regs("regs_after_bad_addr");

        // Reset in the middle of a frame; the tail of that frame must be ignored.
        ncs_low();
        clock_bits(32'h84, 8);
        rst_n = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = '0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        clock_bits(32'hC3, 8);
        ncs_high();
        drain("reset_mid_frame");
        check_regs("regs_after_reset");
        exp_write(4, 8'hC3);
        send(32'h84C3, 16);
        drain("write_c3");

        exp_write(0, 8'h11);
        exp_write(1, 8'h22);
        send(32'h8011, 16);
        send(32'h8122, 16);
        drain("back_to_back");
        check_regs("regs_after_b2b");

        rd_q.push_back(8'hC3);
        send(32'h0400, 16);
        exp_err();
        rd_q.push_back(8'h00);
        send(32'h0700, 16);
        drain("reads_final");

        wait_clks(4);
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL read_pending: %0d reads never seen, required 0", rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
